// File: rtl/ce_gen_pkg.sv
// Shared types and constants for the clock-enable generator bank.
// Pure declarations: no latency, no flow control.
package ce_gen_pkg;

  typedef enum logic [1:0] {
    HOLD,
    COUNT,
    LOCKED
  } state_t;

  localparam int DEF_ACC_W = 32;

  // Increment for a target enable rate: f_target * 2^acc_w / f_ref (f_target must be below 2^(64-acc_w)).
  function automatic logic [63:0] calc_inc(input logic [63:0] f_target,
                                           input logic [63:0] f_ref,
                                           input int          acc_w);
    return (f_target << acc_w) / f_ref;
  endfunction

endpackage

// File: rtl/ce_gen_ch.sv
// One phase-accumulator enable channel; ce is registered one edge after the overflow edge.
// A pending increment is taken on a carry edge (or at once when idle, inc=0, or sync) so no period is cut short.
module ce_gen_ch import ce_gen_pkg::*; #(
  parameter int               ACC_W   = DEF_ACC_W,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sync,
  input  logic             pend,
  input  logic [ACC_W-1:0] pend_inc,
  output logic             apply,
  output logic             ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign apply = pend & (~run | sync | (inc == '0) | sum[ACC_W]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      inc <= RST_INC;
      ce  <= 1'b0;
    end else begin
      if (!run || sync) begin
        acc <= '0;
        ce  <= 1'b0;
      end else begin
        acc <= sum[ACC_W-1:0];
        ce  <= sum[ACC_W];
      end
      // The current edge's sum still uses the old increment.
      if (apply) inc <= pend_inc;
    end
  end

endmodule

// File: rtl/ce_gen_bank.sv
// NUM_CH fractional clock-enable generators with lock sequencing, single-slot retune and phase-align sync.
// locked rises LOCK_CYCLES+1 edges after reset release; cfg_ready is low while a retune waits for its carry edge.
module ce_gen_bank import ce_gen_pkg::*; #(
  parameter int                      NUM_CH      = 4,
  parameter int                      ACC_W       = DEF_ACC_W,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC     = {NUM_CH{32'h8000_0000}},
  localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              sync_i,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] ce_o,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             sync_run;
  logic             pend;
  logic [CH_W-1:0]  pend_ch;
  logic [ACC_W-1:0] pend_inc;
  logic [NUM_CH-1:0] apply;

  assign run       = (state == LOCKED);
  assign sync_run  = sync_i & run;
  assign cfg_ready = ~pend;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state  <= HOLD;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        HOLD: state <= COUNT;
        COUNT: begin
          if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

  // Single retune slot; requests for channels that do not exist are swallowed.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_ch  <= '0;
      pend_inc <= '0;
    end else if (pend) begin
      if (|apply) pend <= 1'b0;
    end else if (cfg_valid && (32'(cfg_ch) < NUM_CH)) begin
      pend     <= 1'b1;
      pend_ch  <= cfg_ch;
      pend_inc <= cfg_inc;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ce_gen_ch #(
      .ACC_W   (ACC_W),
      .RST_INC (DEF_INC[i*ACC_W +: ACC_W])
    ) u_ch (
      .clk      (refclk),
      .rst      (rst),
      .run      (run),
      .sync     (sync_run),
      .pend     (pend && (pend_ch == CH_W'(i))),
      .pend_inc (pend_inc),
      .apply    (apply[i]),
      .ce       (ce_o[i])
    );
  end

endmodule

// File: tb/tb_ce_gen_bank.sv
// Randomized scoreboard bench for ce_gen_bank against a phase-count reference model.
module tb_ce_gen_bank;

  localparam int NUM_CH = 5;
  localparam int ACC_W  = 32;
  localparam int LOCK   = 16;
  localparam logic [NUM_CH*ACC_W-1:0] DEF =
    {32'h2345_6789, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              sync_i = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [2:0]        cfg_ch = '0;
  logic [31:0]       cfg_inc = '0;
  logic [NUM_CH-1:0] ce_o;
  logic              locked;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic              lk;
    logic              rdy;
    logic [NUM_CH-1:0] ce;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: phases as plain integers, lock as edge count since release.
  int              edges;
  longint unsigned m_acc [NUM_CH];
  longint unsigned m_inc [NUM_CH];
  bit              m_ce  [NUM_CH];
  bit              m_pend;
  int              m_pch;
  longint unsigned m_pinc;

  ce_gen_bank #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK),
    .DEF_INC     (DEF)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .sync_i    (sync_i),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .ce_o      (ce_o),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    edges  = 0;
    m_pend = 0;
    m_pch  = 0;
    m_pinc = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = 0;
      m_inc[i] = longint'(DEF[i*ACC_W +: ACC_W]);
      m_ce[i]  = 0;
    end
  endtask

  task automatic model_step();
    bit              run, wrap, applied;
    longint unsigned s;
    exp_t            e;
    if (rst) begin
      model_reset();
      return;
    end
    run     = (edges >= LOCK + 1);
    applied = 0;
    if (edges < 1000000) edges++;
    for (int i = 0; i < NUM_CH; i++) begin
      s    = m_acc[i] + m_inc[i];
      wrap = (s >= 64'h1_0000_0000);
      if (!run || sync_i) begin
        m_acc[i] = 0;
        m_ce[i]  = 0;
      end else begin
        m_acc[i] = s & 64'hFFFF_FFFF;
        m_ce[i]  = wrap;
      end
      if (m_pend && m_pch == i && (!run || sync_i || m_inc[i] == 0 || wrap)) begin
        m_inc[i] = m_pinc;
        applied  = 1;
      end
    end
    if (m_pend) begin
      if (applied) m_pend = 0;
    end else if (cfg_valid && int'(cfg_ch) < NUM_CH) begin
      m_pend = 1;
      m_pch  = int'(cfg_ch);
      m_pinc = longint'(cfg_inc);
    end
    e.lk  = (edges >= LOCK + 1);
    e.rdy = !m_pend;
    for (int i = 0; i < NUM_CH; i++) e.ce[i] = m_ce[i];
    exp_q.push_back(e);
  endtask

  always @(posedge refclk) model_step();

  // Monitor: compares the DUT against the oldest expectation each cycle.
  always @(negedge refclk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_ce", 32'(ce_o), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("locked", 32'(locked), 32'(e.lk));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      chk("ce_o", 32'(ce_o), 32'(e.ce));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic send_cfg(input logic [2:0] ch, input logic [31:0] v);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = v;
    while (!cfg_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) chk("cfg_ready_timeout", 32'(n), 32'd0);
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cfg_ready && n < 100) begin
      tick(1);
      n++;
    end
    chk(name, 32'(cfg_ready), 32'd1);
  endtask

  task automatic pulse_sync();
    sync_i = 1'b1;
    tick(1);
    sync_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, cnt0, cnt3, r;
    logic [2:0]  ch;
    logic [31:0] v;

    model_reset();
    rst = 1'b1;
    tick(5);
    rst = 1'b0;

    k = 0;
    do begin
      tick(1);
      k++;
    end while (!locked && k < 40);
    chk("lock_edges", 32'(k), 32'd17);

    cnt0 = 0;
    cnt3 = 0;
    for (int n = 0; n < 1000; n++) begin
      tick(1);
      cnt0 += int'(ce_o[0]);
      cnt3 += int'(ce_o[3]);
    end
    chk("rate_ch0_pulses", 32'(cnt0), 32'd250);
    chk("rate_ch3_pulses", 32'(cnt3), 32'd0);

    // Retune ch1 from period 2 to period 4 while it is mid-period.
    k = 0;
    while (!ce_o[1] && k < 10) begin
      tick(1);
      k++;
    end
    send_cfg(3'd1, 32'h4000_0000);
    chk("retune_ready_low", 32'(cfg_ready), 32'd0);
    wait_ready("retune_ready_back");
    tick(12);

    // Invalid channel must be swallowed without dropping cfg_ready.
    send_cfg(3'd7, 32'h1234_5678);
    chk("invalid_ready", 32'(cfg_ready), 32'd1);
    tick(6);

    // Sync on a ch2 carry edge with ch0 at a third-rate increment.
    send_cfg(3'd0, 32'h5555_5556);
    wait_ready("sync_setup_ready");
    tick(7);
    if (ce_o[2]) tick(1);
    pulse_sync();
    chk("sync_ce_clear", 32'(ce_o), 32'd0);
    tick(20);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        ch = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0:       v = 32'h0;
          1:       v = 32'h8000_0000;
          default: v = $urandom | 32'h1000_0000;
        endcase
        send_cfg(ch, v);
        if (ch >= 3'(NUM_CH)) chk("rand_invalid_ready", 32'(cfg_ready), 32'd1);
      end else if (r < 7) begin
        pulse_sync();
      end
      tick($urandom_range(1, 8));
    end

    // Async reset with a slow retune still pending.
    send_cfg(3'd4, 32'h0000_1000);
    wait_ready("slow_setup_ready");
    pulse_sync();
    send_cfg(3'd4, 32'hFFFF_0000);
    chk("pending_ready_low", 32'(cfg_ready), 32'd0);
    tick(3);
    rst = 1'b1;
    #1;
    chk("async_locked", 32'(locked), 32'd0);
    chk("async_ce", 32'(ce_o), 32'd0);
    chk("async_ready", 32'(cfg_ready), 32'd1);
    tick(3);
    rst = 1'b0;
    tick(3);
    send_cfg(3'd3, 32'h1000_0000);
    k = 0;
    while (!locked && k < 40) begin
      tick(1);
      k++;
    end
    chk("relock", 32'(locked), 32'd1);
    tick(100);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ce_gen_bank.md
Name: ce_gen_bank

Overview:
- Parametrised successor to the fixed-ratio multi-output PLL wrapper.
- Produces NUM_CH fractional clock-enable pulse trains from one fabric clock, using phase accumulators.
- Provides lock sequencing (locked output), runtime per-channel retune through a valid/ready handshake, and phase-align sync.
- Sits downstream of the system PLL. It feeds CPU, video and sound clock enables, so new core rates need no PLL regeneration.

Parameters:
- NUM_CH, 4, number of enable channels (1..16).
- ACC_W, 32, accumulator and increment width in bits. Output rate = f_refclk * inc / 2^ACC_W.
- LOCK_CYCLES, 1024, refclk cycles after reset release before locked asserts (>=1).
- DEF_INC, {NUM_CH{32'h8000_0000}}, packed NUM_CH*ACC_W reset increments. Channel i uses bits [i*ACC_W +: ACC_W].

Ports:
- refclk  in  1  fabric clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sync_i  in  1  phase-align pulse.
- cfg_valid  in  1  retune request valid.
- cfg_ready  out  1  retune request can be accepted.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_inc  in  ACC_W  new increment.
- ce_o  out  NUM_CH  one-cycle clock-enable pulses.
- locked  out  1  enables valid.

Behaviour:
- Reset (async, rst=1):
  - acc[i]=0, inc[i]=DEF_INC slice, pending cleared.
  - ce_o=0, locked=0, lock counter=0, cfg_ready=1, state=HOLD.
  - Asserting rst mid-operation drops pending retunes immediately.
- State machine:
  - HOLD -> COUNT on the first edge after rst deasserts.
  - COUNT: counter increments each edge. On the edge where the counter reaches LOCK_CYCLES-1, go to LOCKED and set locked=1. locked rises exactly LOCK_CYCLES+1 edges after rst release.
  - LOCKED is terminal until rst.
  - In HOLD/COUNT: accumulators stay at 0 and ce_o=0.
- Accumulate (LOCKED only), per channel each edge:
  - {carry,acc} <= acc + inc (ACC_W+1-bit sum, wrap mod 2^ACC_W).
  - ce_o[i] <= carry. Registered, so ce_o is high in the cycle following the overflow edge.
  - inc=0 never pulses.
  - inc=2^(ACC_W-1) gives the pattern 0,1,0,1 from the first LOCKED edge.
- Retune handshake:
  - Transfer occurs when cfg_valid & cfg_ready. cfg_ready=0 while any retune is pending (single pending slot).
  - Pending inc is applied glitch-free on the first edge where the target channel's carry=1. That edge's sum still uses the old inc; the new inc is used from the next edge.
  - Applied immediately (next edge) if the state is not LOCKED or the target channel's current inc=0.
  - cfg_ready returns to 1 the edge after apply.
  - cfg_ch >= NUM_CH: accepted, discarded, cfg_ready stays 1.
- sync_i (LOCKED):
  - All acc <= 0 and ce_o <= 0 on that edge, regardless of carry (sync wins).
  - Any pending retune is applied on the same edge.
  - sync_i ignored outside LOCKED.
- Simultaneous cfg transfer and apply cannot occur (single slot). A new request is accepted only the cycle after cfg_ready returns high.

Decomposition:
- Package ce_gen_pkg: state enum (HOLD, COUNT, LOCKED), default ACC_W, helper function computing inc from target/ref frequency (for benches and top-level constants).
- Sub-module ce_gen_ch: one accumulator with inc register, carry register, pending-apply input and sync clear.
- The top generates NUM_CH instances plus the lock FSM and cfg slot.

Test Plan:
- Lock timing: rst high 5 cycles then low, LOCK_CYCLES=16 -> locked=0 for 16 edges, 1 at edge 17; ce_o all 0 before locked.
- Rate: ACC_W=32, inc=0x4000_0000 -> ce_o[0] pulses every 4th cycle, exactly 250 pulses in 1000 LOCKED cycles. inc=0 -> zero pulses.
- Retune: ch1 inc 0x8000_0000, request 0x4000_0000 mid-period -> cfg_ready low; period stays 2 until the carry edge, then becomes 4; cfg_ready high one edge after apply; no pulse shorter than the old period.
- Sync: ch0 inc 0x5555_5556 and ch2 inc 0x8000_0000, pulse sync_i on a carry edge -> ce_o=0 next cycle, both accumulators 0, then pulses realign identically to the post-lock start.
- Invalid channel: cfg_ch=7 with NUM_CH=4 -> accepted, cfg_ready never drops, all incs unchanged.
- Async reset mid-retune: assert rst while pending -> ce_o, locked=0 immediately (no clock); after relock, incs equal DEF_INC.
